// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data RAM.
// Supports a bounded bus lock and returns read data one cycle after the grant.
module ram_arbiter #(
   parameter int DEFAULT_RAM_ADDR_WIDTH = 10,
   parameter int ADDR_WIDTH             = DEFAULT_RAM_ADDR_WIDTH,
   parameter int MAX_LOCK               = 16
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  m0_req,
   input  logic                  m0_wr,
   input  logic                  m0_lock,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [31:0]           m0_wr_data,
   input  logic [3:0]            m0_wr_strobe,
   output logic                  m0_gnt,
   output logic                  m0_rd_valid,
   output logic [31:0]           m0_rd_data,

   input  logic                  m1_req,
   input  logic                  m1_wr,
   input  logic                  m1_lock,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [31:0]           m1_wr_data,
   input  logic [3:0]            m1_wr_strobe,
   output logic                  m1_gnt,
   output logic                  m1_rd_valid,
   output logic [31:0]           m1_rd_data,

   output logic                  ram_rd_en,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wr_data,
   output logic [3:0]            ram_wr_strobe,
   input  logic [31:0]           ram_rd_data
);

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t           state_reg, state_next;
   logic             last_reg, last_next;
   logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
   logic [CNT_W-1:0] lock_cnt_inc;
   logic             rd_valid_reg;
   logic             rd_own_reg;

   logic [1:0]            req, wr, lock;
   logic [ADDR_WIDTH-1:0] addr  [2];
   logic [31:0]           wdata [2];
   logic [3:0]            strb  [2];

   logic [1:0] gnt;
   logic       winner;
   logic       any_gnt;
   logic [1:0] rd_valid_vec;

   assign req      = {m1_req, m0_req};
   assign wr       = {m1_wr, m0_wr};
   assign lock     = {m1_lock, m0_lock};
   assign addr[0]  = m0_addr;
   assign addr[1]  = m1_addr;
   assign wdata[0] = m0_wr_data;
   assign wdata[1] = m1_wr_data;
   assign strb[0]  = m0_wr_strobe;
   assign strb[1]  = m1_wr_strobe;

   assign lock_cnt_inc = lock_cnt_reg + CNT_W'(1);

   // Grant decision and next-state; nothing is granted while reset is high.
   always_comb begin
      gnt           = 2'b00;
      winner        = 1'b0;
      state_next    = state_reg;
      last_next     = last_reg;
      lock_cnt_next = lock_cnt_reg;
      if (!rst) begin
         case (state_reg)
            IDLE: begin
               if (req == 2'b11) winner = ~last_reg;
               else              winner = req[1];
               if (req != 2'b00) begin
                  gnt[winner] = 1'b1;
                  last_next   = winner;
                  // With MAX_LOCK of 1 the first grant already exhausts the lock.
                  if (lock[winner] && (MAX_LOCK > 1)) begin
                     state_next    = winner ? LOCK1 : LOCK0;
                     lock_cnt_next = CNT_W'(1);
                  end
               end
            end
            LOCK0, LOCK1: begin
               winner = (state_reg == LOCK1);
               if (req[winner]) begin
                  gnt[winner]   = 1'b1;
                  last_next     = winner;
                  lock_cnt_next = lock_cnt_inc;
               end
               if (!lock[winner] || (req[winner] && (lock_cnt_inc == MAX_CNT))) begin
                  state_next    = IDLE;
                  lock_cnt_next = '0;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign any_gnt       = |gnt;
   assign ram_rd_en     = any_gnt & ~wr[winner];
   assign ram_wr_en     = any_gnt & wr[winner];
   assign ram_addr      = any_gnt ? addr[winner]  : '0;
   assign ram_wr_data   = any_gnt ? wdata[winner] : '0;
   assign ram_wr_strobe = any_gnt ? strb[winner]  : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         last_reg     <= 1'b1;
         lock_cnt_reg <= '0;
         rd_valid_reg <= 1'b0;
         rd_own_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         last_reg     <= last_next;
         lock_cnt_reg <= lock_cnt_next;
         rd_valid_reg <= any_gnt & ~wr[winner];
         if (any_gnt) rd_own_reg <= winner;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         assign rd_valid_vec[gi] = rd_valid_reg & ((gi == 1) ? rd_own_reg : ~rd_own_reg);
      end
   endgenerate

   assign m0_gnt      = gnt[0];
   assign m1_gnt      = gnt[1];
   assign m0_rd_valid = rd_valid_vec[0];
   assign m1_rd_valid = rd_valid_vec[1];
   assign m0_rd_data  = rd_valid_vec[0] ? ram_rd_data : '0;
   assign m1_rd_data  = rd_valid_vec[1] ? ram_rd_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: hand-derived vector table plus randomized traffic
// against a spec-level model of arbitration, locking and RAM contents.
module tb_ram_arbiter;

   localparam int AW       = 8;
   localparam int MAX_LOCK = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [31:0]   m0_wr_data, m1_wr_data;
   logic [3:0]    m0_wr_strobe, m1_wr_strobe;
   logic          m0_gnt, m0_rd_valid, m1_gnt, m1_rd_valid;
   logic [31:0]   m0_rd_data, m1_rd_data;
   logic          ram_rd_en, ram_wr_en;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wr_data;
   logic [3:0]    ram_wr_strobe;
   logic [31:0]   ram_rd_data;

   ram_arbiter #(.ADDR_WIDTH(AW), .MAX_LOCK(MAX_LOCK)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wr_data(m0_wr_data), .m0_wr_strobe(m0_wr_strobe), .m0_gnt(m0_gnt),
      .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wr_data(m1_wr_data), .m1_wr_strobe(m1_wr_strobe), .m1_gnt(m1_gnt),
      .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
      .ram_rd_en(ram_rd_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
      .ram_wr_data(ram_wr_data), .ram_wr_strobe(ram_wr_strobe), .ram_rd_data(ram_rd_data)
   );

   always #5 clk = ~clk;

   // Environment RAM: byte-strobed writes, registered reads.
   logic [31:0] ram_mem [256];
   always @(posedge clk) begin
      if (ram_wr_en)
         for (int b = 0; b < 4; b++)
            if (ram_wr_strobe[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
      if (ram_rd_en) ram_rd_data <= ram_mem[ram_addr];
   end

   typedef struct packed {
      bit          rst;
      bit [1:0]    req, wr, lock;
      logic [7:0]  a0, a1;
      logic [31:0] d0, d1;
      logic [3:0]  s0, s1;
      bit          chk;
      bit [1:0]    eg, erv;
      logic [31:0] erd0, erd1;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          mdl_last, mdl_owner, mdl_cnt, mdl_rdown;
   bit          mdl_rdv;
   logic [31:0] mdl_rddata;
   logic [31:0] mdl_mem [256];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(bit r, bit [1:0] rq, bit [1:0] w, bit [1:0] lk,
                               logic [7:0] a0, logic [31:0] d0, logic [3:0] s0,
                               logic [7:0] a1, logic [31:0] d1, logic [3:0] s1,
                               bit [1:0] eg, bit [1:0] erv, logic [31:0] e0, logic [31:0] e1);
      vec_t v;
      v = '0;
      v.rst = r; v.req = rq; v.wr = w; v.lock = lk;
      v.a0 = a0; v.d0 = d0; v.s0 = s0; v.a1 = a1; v.d1 = d1; v.s1 = s1;
      v.chk = 1'b1; v.eg = eg; v.erv = erv; v.erd0 = e0; v.erd1 = e1;
      return v;
   endfunction

   function automatic int model_winner(vec_t v);
      if (v.rst) return -1;
      if (mdl_owner >= 0) return v.req[mdl_owner] ? mdl_owner : -1;
      if (v.req == 2'b11) return 1 - mdl_last;
      if (v.req[0]) return 0;
      if (v.req[1]) return 1;
      return -1;
   endfunction

   task automatic run_cycle(input vec_t v, output int w);
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      rst = v.rst;
      m0_req = v.req[0]; m0_wr = v.wr[0]; m0_lock = v.lock[0];
      m0_addr = v.a0; m0_wr_data = v.d0; m0_wr_strobe = v.s0;
      m1_req = v.req[1]; m1_wr = v.wr[1]; m1_lock = v.lock[1];
      m1_addr = v.a1; m1_wr_data = v.d1; m1_wr_strobe = v.s1;
      w = model_winner(v);
      a = (w == 1) ? v.a1 : v.a0;
      d = (w == 1) ? v.d1 : v.d0;
      s = (w == 1) ? v.s1 : v.s0;
      @(negedge clk);
      check("gnt", {m1_gnt, m0_gnt}, {62'b0, w == 1, w == 0});
      check("ram_en", {ram_wr_en, ram_rd_en},
            (w < 0) ? 64'd0 : (v.wr[w] ? 64'd2 : 64'd1));
      check("ram_payload", {ram_addr, ram_wr_data, ram_wr_strobe},
            (w < 0) ? 64'd0 : {a, d, s});
      check("rd_valid", {m1_rd_valid, m0_rd_valid},
            {62'b0, mdl_rdv && mdl_rdown == 1, mdl_rdv && mdl_rdown == 0});
      check("rd_data", {m1_rd_data, m0_rd_data},
            {(mdl_rdv && mdl_rdown == 1) ? mdl_rddata : 32'd0,
             (mdl_rdv && mdl_rdown == 0) ? mdl_rddata : 32'd0});
      if (v.chk) begin
         check("tbl_gnt", {m1_gnt, m0_gnt}, v.eg);
         check("tbl_rd_valid", {m1_rd_valid, m0_rd_valid}, v.erv);
         check("tbl_rd_data0", m0_rd_data, v.erd0);
         check("tbl_rd_data1", m1_rd_data, v.erd1);
      end
      if (w >= 0)
         $display("t=%0t m%0d %s addr=%02h wdata=%08h strb=%h lock=%0d",
                  $time, w, v.wr[w] ? "WR" : "RD", a, d, s, v.lock[w]);
      @(posedge clk);
      if (v.rst) begin
         mdl_last = 1; mdl_owner = -1; mdl_cnt = 0; mdl_rdv = 0; mdl_rdown = 0; mdl_rddata = '0;
      end else begin
         mdl_rdv = 0;
         if (w >= 0) begin
            mdl_last = w;
            if (v.wr[w]) begin
               for (int b = 0; b < 4; b++)
                  if (s[b]) mdl_mem[a][8*b +: 8] = d[8*b +: 8];
            end else begin
               mdl_rdv = 1; mdl_rdown = w; mdl_rddata = mdl_mem[a];
            end
         end
         if (mdl_owner >= 0) begin
            if (w >= 0) mdl_cnt++;
            if (!v.lock[mdl_owner] || mdl_cnt == MAX_LOCK) begin
               mdl_owner = -1; mdl_cnt = 0;
            end
         end else if (w >= 0 && v.lock[w] && MAX_LOCK > 1) begin
            mdl_owner = w; mdl_cnt = 1;
         end
      end
      #1;
   endtask

   initial begin
      vec_t        tbl[$];
      vec_t        v;
      int          w;
      bit [1:0]    held;
      logic [31:0] A, B, C;
      bit [1:0]    fg [10];
      A = 32'hDEADBEEF; B = 32'h0D15AA5E; C = 32'h11111111;

      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = '0; mdl_mem[i] = '0;
      end
      ram_rd_data = '0;
      mdl_last = 1; mdl_owner = -1; mdl_cnt = 0; mdl_rdv = 0; mdl_rdown = 0; mdl_rddata = '0;
      v = '0;
      rst = 1'b1;
      m0_req = 0; m0_wr = 0; m0_lock = 0; m0_addr = '0; m0_wr_data = '0; m0_wr_strobe = '0;
      m1_req = 0; m1_wr = 0; m1_lock = 0; m1_addr = '0; m1_wr_data = '0; m1_wr_strobe = '0;
      repeat (2) @(posedge clk);
      #1;

      // reset state, and reset overriding requests
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 0, 8'h10, 0, 0, 8'h20, 0, 0, 0, 0, 0, 0));
      // single master 0 write then read-back
      tbl.push_back(mk(0, 1, 1, 0, 8'h10, A, 4'hF, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, A, 0));
      // byte strobes
      tbl.push_back(mk(0, 1, 1, 0, 8'h20, 32'h0D15EA5E, 4'hF, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 8'h20, 32'h0000AA00, 4'h2, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 8'h20, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, B, 0));
      // continuous contention after reset
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 8'h10, 0, 0, 8'h20, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 8'h10, 0, 0, 8'h20, 0, 0, 2, 1, A, 0));
      tbl.push_back(mk(0, 3, 0, 0, 8'h10, 0, 0, 8'h20, 0, 0, 1, 2, 0, B));
      tbl.push_back(mk(0, 3, 0, 0, 8'h10, 0, 0, 8'h20, 0, 0, 2, 1, A, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, B));
      // voluntary lock by m1 (lock = 1,1,0) with m0 requesting throughout
      tbl.push_back(mk(0, 1, 0, 0, 8'h10, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 3, 2, 2, 8'h10, 0, 0, 8'h30, C, 4'hF, 2, 1, A, 0));
      tbl.push_back(mk(0, 3, 0, 2, 8'h10, 0, 0, 8'h30, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(0, 3, 0, 0, 8'h10, 0, 0, 8'h20, 0, 0, 2, 2, 0, C));
      tbl.push_back(mk(0, 3, 0, 0, 8'h10, 0, 0, 8'h20, 0, 0, 1, 2, 0, B));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, A, 0));
      // forced release at MAX_LOCK: m0 x4, m1 x1, m0 x4, m1 x1
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      fg = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
      for (int i = 0; i < 10; i++) begin
         bit [1:0] rv;
         rv = (i == 0) ? 2'd0 : fg[i-1];
         tbl.push_back(mk(0, 3, 0, 1, 8'h10, 0, 0, 8'h20, 0, 0, fg[i], rv,
                          (rv == 2'd1) ? A : 32'd0, (rv == 2'd2) ? B : 32'd0));
      end
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, B));
      // reset while m1 holds the lock with a read in flight
      tbl.push_back(mk(0, 2, 0, 2, 8'h10, 0, 0, 8'h20, 0, 0, 2, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 2, 8'h10, 0, 0, 8'h20, 0, 0, 0, 2, 0, B));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 3, 0, 2, 8'h10, 0, 0, 8'h20, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, A, 0));

      foreach (tbl[i]) run_cycle(tbl[i], w);

      // randomized traffic; a stalled master keeps its request and payload
      held = 2'b00;
      for (int n = 0; n < 400; n++) begin
         v.rst = ($urandom_range(0, 49) == 0);
         v.chk = 1'b0;
         if (!held[0]) begin
            v.req[0]  = ($urandom_range(0, 3) != 0);
            v.wr[0]   = ($urandom_range(0, 2) == 0);
            v.lock[0] = $urandom_range(0, 1) != 0;
            v.a0 = 8'($urandom_range(0, 15));
            v.d0 = $urandom;
            v.s0 = 4'($urandom_range(0, 15));
         end
         if (!held[1]) begin
            v.req[1]  = ($urandom_range(0, 3) != 0);
            v.wr[1]   = ($urandom_range(0, 2) == 0);
            v.lock[1] = $urandom_range(0, 1) != 0;
            v.a1 = 8'($urandom_range(0, 15));
            v.d1 = $urandom;
            v.s1 = 4'($urandom_range(0, 15));
         end
         run_cycle(v, w);
         held[0] = v.req[0] && !v.rst && (w != 0);
         held[1] = v.req[1] && !v.rst && (w != 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
